vga_scan_compositor: RTL and testbench
======================================

Name: vga_scan_compositor

Overview:
- Master end of the object pixel interface. Generates the 640x480 raster (hcount, vcount, enable) that every game object samples.
- Collects each object's registered 1-bit red/green/blue plus layer flag and resolves priority to one pixel.
- Drives the VGA pins (rgb, hsync, vsync), delayed so sync stays aligned with object pixel latency. Sits at top level between all game objects and the connector.

Parameters:
- NUM_OBJ, 4: number of game objects attached.
- CLK_DIV, 2: system clocks per pixel. 50 MHz / 2 = 25 MHz pixel rate.
- H_VIS, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal timing in pixels.
- V_VIS, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical timing in lines.
- BG_RGB, 3'b000: background colour {r,g,b} when no object is lit.

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- hcount  out  10  current pixel column, to all objects.
- vcount  out  10  current line, to all objects.
- enable  out  1  high while (hcount,vcount) is in the visible area.
- obj_red  in  NUM_OBJ  bit i = red from object i.
- obj_green  in  NUM_OBJ  bit i = green from object i.
- obj_blue  in  NUM_OBJ  bit i = blue from object i.
- obj_layer  in  NUM_OBJ  bit i = layer of object i (1 = front).
- red, green, blue  out  1 each  composited pixel to DAC.
- hsync  out  1  active-low horizontal sync.
- vsync  out  1  active-low vertical sync.
- frame_start  out  1  one-clock pulse at start of each frame.

Behaviour:
- Reset (async, resetn=0):
  - Divider, hcount, vcount = 0; enable = 0.
  - red/green/blue = 0; hsync = vsync = 1; frame_start = 0.
  - All pipeline registers cleared.
  - Release takes effect on the next clock edge. Reset mid-frame restarts at (0,0) with no partial-line output.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - tick = (div == CLK_DIV-1). Raster counters advance only on tick.
- Horizontal counter:
  - H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800).
  - hcount wraps H_TOTAL-1 -> 0. vcount increments on that wrap.
- Vertical counter:
  - V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (525).
  - vcount wraps V_TOTAL-1 -> 0 when hcount wraps on the last line.
- enable is registered with the counters: enable = (hcount < H_VIS) && (vcount < V_VIS).
- Raw sync, computed from the stage-0 counters:
  - hs_raw low for H_VIS+H_FP <= hcount < H_VIS+H_FP+H_SYNC (656..751).
  - vs_raw low for 480+10 <= vcount < 492 (lines 490..491).
- Latency:
  - Stage 0 = counters.
  - Stage 1 = object registers (objects register rgb on the clock after sampling).
  - Stage 2 = compositor output register.
  - hs_raw, vs_raw and enable pass through a 2-deep delay line, so hsync, vsync and active-video-out align with red/green/blue.
- Compositing, at stage 2, from registered object inputs:
  - Object i is lit if any of its r/g/b bits is 1.
  - Winner = lowest-index lit object with layer=1. If none, lowest-index lit object with layer=0. If none, BG_RGB.
  - If the delayed enable is 0, output rgb = 000 regardless of objects (blanking).
- frame_start:
  - Pulses high for exactly one clock, on the clock where tick wraps (hcount,vcount) to (0,0).
  - Not delayed. Objects use it for once-per-frame motion updates.
- Arithmetic:
  - Counters are 10-bit unsigned.
  - Parameters must satisfy H_TOTAL, V_TOTAL <= 1024. Elaboration error otherwise.
- Simultaneous events: the hcount and vcount wrap occur on the same tick. frame_start is asserted on that same clock.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined:
  - Adds input port test_mode (1 bit).
  - When test_mode=1, composited rgb is replaced by colour bars: bar = hcount_delayed/80 (0..7), rgb = bar[2:0].
  - Blanking and sync are unchanged; objects are ignored.
  - test_mode is sampled at stage 2.
- Not defined: no test_mode port; compositing only.

Test Plan:
- Reset release, CLK_DIV=2:
  - hcount increments every 2 clocks.
  - hcount 799 -> 0 with vcount +1.
  - frame period = 800*525*2 = 840000 clocks.
- Sync timing:
  - hsync low for exactly 96 pixel ticks, starting 2 clocks after hcount reaches 656.
  - vsync low across lines 490-491.
  - enable low for hcount >= 640.
- Priority:
  - obj0 = red layer0, obj2 = blue layer1, both lit → output 001.
  - Drop obj2 → output 100.
  - obj1 = green layer0 as well as obj0 → obj0 wins.
- Blanking:
  - Objects held at 111 during hcount 700 → rgb = 000.
  - BG_RGB = 3'b010 with no object lit in visible area → 010.
- Reset mid-line at hcount 300, vcount 100:
  - Outputs immediately 0 / hsync=vsync=1.
  - After release, counters restart at (0,0).
  - frame_start fires on the first frame wrap only.
- VGA_TEST_PATTERN_EN with test_mode=1:
  - Pixel 0 → 000, pixel 85 → 001, pixel 639 → 111.

Source files
------------

// File: rtl/vga_scan_compositor.sv
// 640x480 raster master and object pixel compositor driving the VGA pins.
// Optional colour-bar test pattern (adds test_mode port) under VGA_TEST_PATTERN_EN.
module vga_scan_compositor #(
  parameter int unsigned NUM_OBJ = 4,
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned H_VIS   = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_VIS   = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33,
  parameter logic [2:0]  BG_RGB  = 3'b000
) (
  input  logic               clock,
  input  logic               resetn,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               test_mode,
`endif
  input  logic [NUM_OBJ-1:0] obj_red,
  input  logic [NUM_OBJ-1:0] obj_green,
  input  logic [NUM_OBJ-1:0] obj_blue,
  input  logic [NUM_OBJ-1:0] obj_layer,
  output logic [9:0]         hcount,
  output logic [9:0]         vcount,
  output logic               enable,
  output logic               red,
  output logic               green,
  output logic               blue,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_start
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS_L  = 11'(H_VIS);
  localparam logic [10:0] V_VIS_L  = 11'(V_VIS);
  localparam logic [10:0] HS_START = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VIS + V_FP + V_SYNC);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_timing_check
    $error("vga_scan_compositor: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV == 0 || NUM_OBJ == 0) begin : g_param_check
    $error("vga_scan_compositor: CLK_DIV and NUM_OBJ must be at least 1");
  end

  logic [DIV_W-1:0] div;
  logic             tick;
  logic [9:0]       h_next, v_next;
  logic             frame_wrap;
  logic             hs_raw, vs_raw;
  logic             hs_d1, vs_d1, en_d1;
  logic [NUM_OBJ-1:0] obj_lit;
  logic             front_hit, back_hit;
  logic [2:0]       front_rgb, back_rgb;
  logic [2:0]       pix_c;

  assign tick = (div == DIV_W'(CLK_DIV - 1));

  // Raster counter next state; both wraps land on the same tick
  always_comb begin
    h_next     = hcount;
    v_next     = vcount;
    frame_wrap = 1'b0;
    if (tick) begin
      if (hcount == H_LAST) begin
        h_next = 10'd0;
        if (vcount == V_LAST) begin
          v_next     = 10'd0;
          frame_wrap = 1'b1;
        end else begin
          v_next = vcount + 10'd1;
        end
      end else begin
        h_next = hcount + 10'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      div         <= '0;
      hcount      <= 10'd0;
      vcount      <= 10'd0;
      enable      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= tick ? '0 : div + DIV_W'(1);
      hcount      <= h_next;
      vcount      <= v_next;
      frame_start <= frame_wrap;
      if (tick) begin
        enable <= ({1'b0, h_next} < H_VIS_L) && ({1'b0, v_next} < V_VIS_L);
      end
    end
  end

  assign hs_raw = !(({1'b0, hcount} >= HS_START) && ({1'b0, hcount} < HS_END));
  assign vs_raw = !(({1'b0, vcount} >= VS_START) && ({1'b0, vcount} < VS_END));

  // Priority resolve: scan high to low so the lowest lit index of each layer wins
  assign obj_lit = obj_red | obj_green | obj_blue;

  always_comb begin
    front_hit = 1'b0;
    back_hit  = 1'b0;
    front_rgb = 3'b000;
    back_rgb  = 3'b000;
    for (int i = int'(NUM_OBJ) - 1; i >= 0; i--) begin
      if (obj_lit[i] && obj_layer[i]) begin
        front_hit = 1'b1;
        front_rgb = {obj_red[i], obj_green[i], obj_blue[i]};
      end
      if (obj_lit[i] && !obj_layer[i]) begin
        back_hit = 1'b1;
        back_rgb = {obj_red[i], obj_green[i], obj_blue[i]};
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [9:0] hcount_d1;
  logic [2:0] bar;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) hcount_d1 <= 10'd0;
    else         hcount_d1 <= hcount;
  end

  assign bar = 3'(hcount_d1 / 10'd80);
`endif

  always_comb begin
    pix_c = BG_RGB;
    if (!en_d1) begin
      pix_c = 3'b000;
`ifdef VGA_TEST_PATTERN_EN
    end else if (test_mode) begin
      pix_c = bar;
`endif
    end else if (front_hit) begin
      pix_c = front_rgb;
    end else if (back_hit) begin
      pix_c = back_rgb;
    end
  end

  // Two-stage alignment of sync/enable with the object register plus output register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hs_d1 <= 1'b1;
      vs_d1 <= 1'b1;
      en_d1 <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      red   <= 1'b0;
      green <= 1'b0;
      blue  <= 1'b0;
    end else begin
      hs_d1 <= hs_raw;
      vs_d1 <= vs_raw;
      en_d1 <= enable;
      hsync <= hs_d1;
      vsync <= vs_d1;
      {red, green, blue} <= pix_c;
    end
  end

endmodule

// File: tb/tb_vga_scan_compositor.sv
// Scoreboard bench for vga_scan_compositor with a shortened vertical frame.
module tb_vga_scan_compositor;

  localparam int unsigned NOBJ = 4;
  localparam int unsigned VV = 4, VF = 1, VS = 2, VB = 1;
  localparam int unsigned FRAME_CLKS = 800 * 8 * 2;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic [NOBJ-1:0] obj_red = '0, obj_green = '0, obj_blue = '0, obj_layer = '0;
  logic [9:0] hcount, vcount;
  logic enable, red, green, blue, hsync, vsync, frame_start;
`ifdef VGA_TEST_PATTERN_EN
  logic test_mode = 1'b0;
`endif

  vga_scan_compositor #(
    .NUM_OBJ(NOBJ), .CLK_DIV(2),
    .H_VIS(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .BG_RGB(3'b010)
  ) dut (
    .clock(clock), .resetn(resetn),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .obj_red(obj_red), .obj_green(obj_green), .obj_blue(obj_blue), .obj_layer(obj_layer),
    .hcount(hcount), .vcount(vcount), .enable(enable),
    .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic [4:0] exp;   // {r,g,b,hsync,vsync}
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic req = 1'b0;
  logic [1:0] req_d = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Output for a pixel appears two clocks after its counters
  always @(posedge clock) req_d <= {req_d[0], req};

  always @(negedge clock) begin : monitor
    exp_t e;
    if (req_d[1]) begin
      if (sb.size() == 0) begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check(e.name, {27'd0, red, green, blue, hsync, vsync}, {27'd0, e.exp});
      end
    end
  end

  task automatic wait_pix(input int h, input int v, output bit ok);
    logic [9:0] last;
    last = hcount;
    ok   = 1'b0;
    for (int n = 0; n < 40000; n++) begin
      @(negedge clock);
      if (hcount == 10'(h) && vcount == 10'(v) && last != 10'(h)) begin
        ok = 1'b1;
        break;
      end
      last = hcount;
    end
  endtask

  task automatic expect_pix(input string name, input int h, input int v,
                            input logic [2:0] rgb, input logic hs, input logic vs);
    bit   ok;
    exp_t e;
    wait_pix(h, v, ok);
    if (!ok) begin
      check({"timeout_", name}, 32'd0, 32'd1);
      return;
    end
    e.name = name;
    e.exp  = {rgb, hs, vs};
    sb.push_back(e);
    req = 1'b1;
    @(negedge clock);
    req = 1'b0;
  endtask

  task automatic set_obj(input logic [NOBJ-1:0] r, input logic [NOBJ-1:0] g,
                         input logic [NOBJ-1:0] b, input logic [NOBJ-1:0] l);
    repeat (3) @(negedge clock);
    obj_red = r; obj_green = g; obj_blue = b; obj_layer = l;
  endtask

  initial begin
    bit ok;
    int cnt;
    int fs;

    repeat (3) @(negedge clock);
    check("rst_hcount", 32'(hcount), 32'd0);
    check("rst_vcount", 32'(vcount), 32'd0);
    check("rst_enable", 32'(enable), 32'd0);
    check("rst_rgb", 32'({red, green, blue}), 32'd0);
    check("rst_sync", 32'({hsync, vsync}), 32'd3);
    check("rst_frame_start", 32'(frame_start), 32'd0);

    resetn = 1'b1;
    cnt = 0;
    do begin @(negedge clock); cnt++; end while (hcount != 10'd1 && cnt < 10);
    check("first_tick_clocks", 32'(cnt), 32'd2);
    cnt = 0;
    do begin @(negedge clock); cnt++; end while (hcount != 10'd2 && cnt < 10);
    check("pixel_period_clocks", 32'(cnt), 32'd2);

    expect_pix("bg_visible_line0", 10, 0, 3'b010, 1'b1, 1'b1);
    wait_pix(639, 0, ok);
    check("enable_h639", 32'({ok, enable}), 32'd3);
    wait_pix(640, 0, ok);
    check("enable_h640", 32'({ok, enable}), 32'd2);

    expect_pix("hsync_h655", 655, 0, 3'b000, 1'b1, 1'b1);
    expect_pix("hsync_h656", 656, 0, 3'b000, 1'b0, 1'b1);
    expect_pix("hsync_h751", 751, 0, 3'b000, 1'b0, 1'b1);
    expect_pix("hsync_h752", 752, 0, 3'b000, 1'b1, 1'b1);

    set_obj(4'b0001, 4'b0000, 4'b0100, 4'b0100);
    expect_pix("prio_front_blue", 100, 1, 3'b001, 1'b1, 1'b1);
    set_obj(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    expect_pix("prio_drop_front", 200, 1, 3'b100, 1'b1, 1'b1);
    set_obj(4'b0001, 4'b0010, 4'b0000, 4'b0000);
    expect_pix("prio_lowest_back", 300, 1, 3'b100, 1'b1, 1'b1);
    set_obj(4'b1001, 4'b0010, 4'b0010, 4'b1010);
    expect_pix("prio_lowest_front", 400, 1, 3'b011, 1'b1, 1'b1);
    set_obj(4'b1111, 4'b1111, 4'b1111, 4'b0000);
    expect_pix("blank_h700", 700, 1, 3'b000, 1'b0, 1'b1);
    set_obj(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    expect_pix("bg_visible_line2", 50, 2, 3'b010, 1'b1, 1'b1);

`ifdef VGA_TEST_PATTERN_EN
    set_obj(4'b1111, 4'b1111, 4'b1111, 4'b1111);
    test_mode = 1'b1;
    expect_pix("bars_px0", 0, 3, 3'b000, 1'b1, 1'b1);
    expect_pix("bars_px85", 85, 3, 3'b001, 1'b1, 1'b1);
    expect_pix("bars_px639", 639, 3, 3'b111, 1'b1, 1'b1);
    expect_pix("bars_blank_h700", 700, 3, 3'b000, 1'b0, 1'b1);
    repeat (3) @(negedge clock);
    test_mode = 1'b0;
    obj_red = '0; obj_green = '0; obj_blue = '0; obj_layer = '0;
`endif

    expect_pix("vsync_line4", 10, 4, 3'b000, 1'b1, 1'b1);
    expect_pix("vsync_line5", 10, 5, 3'b000, 1'b1, 1'b0);
    expect_pix("vsync_line6", 10, 6, 3'b000, 1'b1, 1'b0);
    expect_pix("vsync_line7", 10, 7, 3'b000, 1'b1, 1'b1);

    wait_pix(0, 0, ok);
    check("frame_start_at_wrap", 32'({ok, frame_start}), 32'd3);
    @(negedge clock);
    check("frame_start_one_clock", 32'(frame_start), 32'd0);
    cnt = 1;
    while (cnt < 20000) begin
      @(negedge clock);
      cnt++;
      if (frame_start) break;
    end
    check("frame_period_clocks", 32'(cnt), 32'(FRAME_CLKS));

    obj_red = 4'b0001;
    wait_pix(300, 3, ok);
    check("pre_reset_rgb", 32'({ok, red, green, blue}), 32'b1100);
    resetn = 1'b0;
    #1;
    check("midreset_rgb", 32'({red, green, blue}), 32'd0);
    check("midreset_sync", 32'({hsync, vsync}), 32'd3);
    check("midreset_counters", 32'({vcount, hcount}), 32'd0);
    check("midreset_enable", 32'(enable), 32'd0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    check("restart_counters", 32'({vcount, hcount}), 32'd1);
    fs = 0;
    for (int n = 0; n < int'(FRAME_CLKS) + 10; n++) begin
      @(negedge clock);
      if (frame_start) begin
        fs++;
        check("frame_start_position", 32'({vcount, hcount}), 32'd0);
      end
    end
    check("frame_start_count_after_reset", 32'(fs), 32'd1);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
